// File: rtl/adder_pkg.sv
// Shared types and widths for the accumulator stage and its prefix adder.
package adder_pkg;

    localparam int unsigned ADD_W     = 16;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/adder_accum_ctrl_if.sv
// Operand stream, result stream and control for the accumulator stage.
interface adder_accum_ctrl_if
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = ADD_W,
    parameter int unsigned CNT_W = CNT_W_DEF
);

    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_sum;
    logic             out_ovf;
    logic [CNT_W-1:0] out_count;
    logic             out_ready;
    logic             busy;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, out_count, busy
    );

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, out_count, busy
    );

endinterface

// File: rtl/adder_prefix.sv
// Combinational Kogge-Stone prefix adder, carry-in tied to zero.
module adder_prefix
    import adder_pkg::*;
(
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    output logic [ADD_W-1:0] sum,
    output logic             cout
);

    localparam int unsigned LVLS = $clog2(ADD_W);

    logic [ADD_W-1:0] p0;
    logic [ADD_W-1:0] gk;
    logic [ADD_W-1:0] pk;
    logic [ADD_W-1:0] gn;
    logic [ADD_W-1:0] pn;

    // gk[i] ends up as the group generate of bits [i:0], i.e. carry into bit i+1
    always_comb begin
        p0 = a ^ b;
        gk = a & b;
        pk = p0;
        gn = '0;
        pn = '0;
        for (int l = 0; l < int'(LVLS); l++) begin
            gn = gk;
            pn = pk;
            for (int i = 0; i < int'(ADD_W); i++) begin
                if (i >= (1 << l)) begin
                    gn[i] = gk[i] | (pk[i] & gk[i - (1 << l)]);
                    pn[i] = pk[i] & pk[i - (1 << l)];
                end
            end
            gk = gn;
            pk = pn;
        end
    end

    assign sum  = p0 ^ {gk[ADD_W-2:0], 1'b0};
    assign cout = gk[ADD_W-1];

endmodule

// File: rtl/adder_accum_ctrl.sv
// Accumulates a stream of len operands through an external adder and
// returns the wrapped sum, sticky carry flag and operand count.
module adder_accum_ctrl
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = ADD_W,
    parameter int unsigned CNT_W = CNT_W_DEF
)(
    input  logic                clk,
    input  logic                rst_n,
    adder_accum_ctrl_if.slave   bus,
    output logic [WIDTH-1:0]    adder_a,
    output logic [WIDTH-1:0]    adder_b,
    input  logic [WIDTH-1:0]    adder_sum,
    input  logic                adder_cout
);

    acc_state_t       state;
    acc_state_t       state_n;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_n;
    logic             ovf;
    logic             ovf_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] len_n;
    logic             in_ready;
    logic             out_valid;
    logic             busy;

    assign cnt_inc = cnt + CNT_W'(1);

    // Next state and datapath updates
    always_comb begin
        state_n = state;
        acc_n   = acc;
        ovf_n   = ovf;
        cnt_n   = cnt;
        len_n   = len_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_n   = '0;
                    ovf_n   = 1'b0;
                    cnt_n   = '0;
                    len_n   = bus.len;
                    state_n = (bus.len != '0) ? ACCUM : DONE;
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    acc_n = adder_sum;
                    ovf_n = ovf | adder_cout;
                    cnt_n = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            cnt       <= '0;
            len_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            ovf       <= ovf_n;
            cnt       <= cnt_n;
            len_q     <= len_n;
            in_ready  <= (state_n == ACCUM);
            out_valid <= (state_n == DONE);
            busy      <= (state_n != IDLE);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.out_sum   = acc;
    assign bus.out_ovf   = ovf;
    assign bus.out_count = cnt;
    assign adder_a       = acc;
    assign adder_b       = bus.in_data;

endmodule

// File: tb/tb_adder_accum_ctrl.sv
// Directed bench for adder_accum_ctrl wired to the prefix adder.
module tb_adder_accum_ctrl;
    import adder_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adder_accum_ctrl_if bus();

    logic [ADD_W-1:0] adder_a;
    logic [ADD_W-1:0] adder_b;
    logic [ADD_W-1:0] adder_sum;
    logic             adder_cout;

    adder_accum_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_sum  (adder_sum),
        .adder_cout (adder_cout)
    );

    adder_prefix u_add (
        .a    (adder_a),
        .b    (adder_b),
        .sum  (adder_sum),
        .cout (adder_cout)
    );

    int errors = 0;
    int checks = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] n);
        bus.start = 1'b1;
        bus.len   = n;
        tick();
        bus.start = 1'b0;
        bus.len   = 8'hFF;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.len       = 8'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {bus.in_ready, bus.out_valid, bus.busy});
        end
        checks++;
        if ({bus.out_sum, bus.out_ovf, bus.out_count} !== 25'h0) begin
            errors++;
            $display("FAIL reset_result: got %h expected 0", {bus.out_sum, bus.out_ovf, bus.out_count});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy: got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        do_start(8'd4);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0100;
        tick();
        bus.in_data  = 16'h0200;
        tick();
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_flags: got %b expected 000", {bus.in_ready, bus.out_valid, bus.busy});
        end
        checks++;
        if ({bus.out_sum, bus.out_count} !== 24'h0) begin
            errors++;
            $display("FAIL midreset_state: got %h expected 0", {bus.out_sum, bus.out_count});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_start(8'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h00AA;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.out_sum, bus.out_ovf, bus.out_count} !== {1'b1, 16'h00AA, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL midreset_fresh: got v=%b s=%h o=%b c=%0d expected v=1 s=00aa o=0 c=1",
                     bus.out_valid, bus.out_sum, bus.out_ovf, bus.out_count);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_start(8'd3);
        checks++;
        if ({bus.in_ready, bus.busy} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_ready_latency: got ready=%b busy=%b expected 1 1", bus.in_ready, bus.busy);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0001;
        tick();
        bus.in_data  = 16'h0002;
        tick();
        bus.in_data  = 16'h0003;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_early_valid: got %b expected 0", bus.out_valid);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_done_flags: got valid=%b ready=%b expected 1 0", bus.out_valid, bus.in_ready);
        end
        checks++;
        if ({bus.out_sum, bus.out_ovf, bus.out_count} !== {16'h0006, 1'b0, 8'd3}) begin
            errors++;
            $display("FAIL b2b_result: got s=%h o=%b c=%0d expected s=0006 o=0 c=3",
                     bus.out_sum, bus.out_ovf, bus.out_count);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if ({bus.out_valid, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_idle: got valid=%b busy=%b expected 0 0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_overflow();
        do_start(8'd2);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hFFFF;
        tick();
        bus.in_data  = 16'h0002;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.out_sum, bus.out_ovf, bus.out_count} !== {1'b1, 16'h0001, 1'b1, 8'd2}) begin
            errors++;
            $display("FAIL ovf_result: got v=%b s=%h o=%b c=%0d expected v=1 s=0001 o=1 c=2",
                     bus.out_valid, bus.out_sum, bus.out_ovf, bus.out_count);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_len_zero();
        do_start(8'd0);
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL len0_flags: got valid=%b ready=%b expected 1 0", bus.out_valid, bus.in_ready);
        end
        checks++;
        if ({bus.out_sum, bus.out_ovf, bus.out_count} !== 25'h0) begin
            errors++;
            $display("FAIL len0_result: got s=%h o=%b c=%0d expected s=0000 o=0 c=0",
                     bus.out_sum, bus.out_ovf, bus.out_count);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL len0_idle: got busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_stall();
        logic [15:0] data [4];
        int          gap  [4];
        data = '{16'h1234, 16'h8000, 16'h9000, 16'h0F0F};
        gap  = '{0, 1, 2, 3};
        do_start(8'd4);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 16'hDEAD;
            for (int g = 0; g < gap[i]; g++) begin
                tick();
                checks++;
                if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
                    errors++;
                    $display("FAIL stall_gap_%0d_%0d: got ready=%b valid=%b expected 1 0",
                             i, g, bus.in_ready, bus.out_valid);
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = data[i];
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.out_sum, bus.out_ovf, bus.out_count} !== {1'b1, 16'h3143, 1'b1, 8'd4}) begin
            errors++;
            $display("FAIL stall_result: got v=%b s=%h o=%b c=%0d expected v=1 s=3143 o=1 c=4",
                     bus.out_valid, bus.out_sum, bus.out_ovf, bus.out_count);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({bus.out_valid, bus.out_sum, bus.out_ovf, bus.out_count} !== {1'b1, 16'h3143, 1'b1, 8'd4}) begin
                errors++;
                $display("FAIL stall_hold_%0d: got v=%b s=%h o=%b c=%0d expected v=1 s=3143 o=1 c=4",
                         k, bus.out_valid, bus.out_sum, bus.out_ovf, bus.out_count);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if ({bus.out_valid, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL stall_idle: got valid=%b busy=%b expected 0 0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_start_ignored();
        do_start(8'd2);
        bus.start    = 1'b1;
        bus.len      = 8'd7;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0010;
        tick();
        bus.start    = 1'b0;
        bus.in_data  = 16'h0020;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.out_sum, bus.out_count} !== {1'b1, 16'h0030, 8'd2}) begin
            errors++;
            $display("FAIL ign_accum_start: got v=%b s=%h c=%0d expected v=1 s=0030 c=2",
                     bus.out_valid, bus.out_sum, bus.out_count);
        end
        bus.start     = 1'b1;
        bus.len       = 8'd5;
        bus.out_ready = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if ({bus.busy, bus.out_valid, bus.in_ready} !== 3'b000) begin
            errors++;
            $display("FAIL ign_done_start: got busy=%b valid=%b ready=%b expected 0 0 0",
                     bus.busy, bus.out_valid, bus.in_ready);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ign_stays_idle: got busy=%b expected 0", bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_back_to_back();
        test_overflow();
        test_len_zero();
        test_stall();
        test_start_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
